// File: rtl/tetris_piece_queue.sv
// Piece generator and preview FIFO: a 16-bit Galois LFSR feeds a 7-bag (or
// rejection-random) picker, and the head entry is presented as a spawn-ready piece.
module tetris_piece_queue #(
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [3:0]  SPAWN_X       = 4'd3,
    parameter logic [4:0]  SPAWN_Y       = 5'd0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter bit          BAG_MODE      = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         seed_load,
    input  logic [15:0]                  seed_in,
    input  logic                         take,
    output logic                         piece_valid,
    output logic [13:0]                  piece,
    output logic [3*PREVIEW_DEPTH-1:0]   preview_types,
    output logic [PREVIEW_DEPTH-1:0]     preview_valid,
    output logic [15:0]                  pieces_dealt
);
    localparam int            CAP       = PREVIEW_DEPTH + 1;
    localparam int            CW        = $clog2(CAP + 1);
    localparam logic [CW-1:0] CAP_C     = CW'(CAP);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [CW-1:0] ZERO_C    = CW'(0);
    localparam logic [2:0]    PIECE_I   = 3'd0;
    localparam logic [1:0]    ROT_0     = 2'd0;
    localparam logic [15:0]   LFSR_MASK = 16'hB400;

    // First unused bag slot, scanning upward from the candidate with wrap at 7.
    function automatic logic [2:0] bag_pick(input logic [2:0] cand, input logic [6:0] used);
        logic [2:0] start;
        logic [2:0] idx;
        logic       found;
        start    = (cand == 3'd7) ? 3'd0 : cand;
        bag_pick = start;
        found    = 1'b0;
        for (int k = 0; k < 7; k++) begin
            idx = 3'((int'(start) + k) % 7);
            if (!found && !used[idx]) begin
                bag_pick = idx;
                found    = 1'b1;
            end
        end
    endfunction

    logic [15:0]              lfsr_r, lfsr_s;
    logic [CW-1:0]            count_r, count_s, base_s;
    logic [6:0]               bag_used_r, bag_used_s, bag_set_s;
    logic [2:0]               queue_r [CAP];
    logic [2:0]               queue_s [CAP];
    logic [15:0]              dealt_r, dealt_s;
    logic                     piece_valid_r, piece_valid_s;
    logic [PREVIEW_DEPTH-1:0] preview_valid_r, preview_valid_s;
    logic [2:0]               cand_s, push_type_s;
    logic                     pop_s, push_s;

    // Next-state: LFSR step, pop-then-push FIFO update, bag bookkeeping, flush.
    always_comb begin
        cand_s      = lfsr_r[2:0];
        lfsr_s      = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_MASK : 16'h0000);
        count_s     = count_r;
        base_s      = count_r;
        bag_used_s  = bag_used_r;
        dealt_s     = dealt_r;
        queue_s     = queue_r;
        pop_s       = take && (count_r != ZERO_C);
        if (BAG_MODE) begin
            push_type_s = bag_pick(cand_s, bag_used_r);
            push_s      = (count_r < CAP_C);
        end else begin
            push_type_s = cand_s;
            push_s      = (count_r < CAP_C) && (cand_s != 3'd7);
        end
        bag_set_s = bag_used_r | (7'd1 << push_type_s);

        if (seed_load) begin
            lfsr_s     = (seed_in == 16'h0000) ? LFSR_SEED : seed_in;
            count_s    = ZERO_C;
            bag_used_s = 7'h00;
            for (int i = 0; i < CAP; i++) begin
                queue_s[i] = 3'd0;
            end
        end else begin
            if (pop_s) begin
                for (int i = 0; i < CAP - 1; i++) begin
                    queue_s[i] = queue_r[i+1];
                end
                queue_s[CAP-1] = 3'd0;
                base_s         = count_r - ONE_C;
                dealt_s        = dealt_r + 16'd1;
            end else begin
                base_s = count_r;
            end
            if (push_s) begin
                for (int i = 0; i < CAP; i++) begin
                    queue_s[i] = (CW'(i) == base_s) ? push_type_s : queue_s[i];
                end
                count_s = base_s + ONE_C;
                if (BAG_MODE) begin
                    bag_used_s = (bag_set_s == 7'h7F) ? 7'h00 : bag_set_s;
                end else begin
                    bag_used_s = 7'h00;
                end
            end else begin
                count_s = base_s;
            end
        end

        piece_valid_s = (count_s != ZERO_C);
        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            preview_valid_s[i] = (int'(count_s) >= i + 2);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r          <= LFSR_SEED;
            count_r         <= ZERO_C;
            bag_used_r      <= 7'h00;
            dealt_r         <= 16'h0000;
            piece_valid_r   <= 1'b0;
            preview_valid_r <= {PREVIEW_DEPTH{1'b0}};
            for (int i = 0; i < CAP; i++) begin
                queue_r[i] <= PIECE_I;
            end
        end else begin
            lfsr_r          <= lfsr_s;
            count_r         <= count_s;
            bag_used_r      <= bag_used_s;
            dealt_r         <= dealt_s;
            piece_valid_r   <= piece_valid_s;
            preview_valid_r <= preview_valid_s;
            for (int i = 0; i < CAP; i++) begin
                queue_r[i] <= queue_s[i];
            end
        end
    end

    assign piece_valid   = piece_valid_r;
    assign piece         = {queue_r[0], ROT_0, SPAWN_X, SPAWN_Y};
    assign preview_valid = preview_valid_r;
    assign pieces_dealt  = dealt_r;

    for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
        assign preview_types[3*g +: 3] = queue_r[g+1];
    end
endmodule

// File: tb/tb_tetris_piece_queue.sv
// Scoreboard bench for tetris_piece_queue: a queue-based bag model predicts every
// cycle's outputs and every dealt piece; a second instance exercises random mode.
module tb_tetris_piece_queue;
    localparam int PD = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, seed_load, take;
    logic [15:0] seed_in;
    logic        piece_valid;
    logic [13:0] piece;
    logic [3*PD-1:0] preview_types;
    logic [PD-1:0]   preview_valid;
    logic [15:0] pieces_dealt;

    logic        r_reset, r_seed_load, r_take;
    logic [15:0] r_seed_in;
    logic        r_piece_valid;
    logic [13:0] r_piece;
    logic [3*PD-1:0] r_preview_types;
    logic [PD-1:0]   r_preview_valid;
    logic [15:0] r_pieces_dealt;

    tetris_piece_queue #(.PREVIEW_DEPTH(PD), .BAG_MODE(1'b1)) dut (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in), .take(take),
        .piece_valid(piece_valid), .piece(piece), .preview_types(preview_types),
        .preview_valid(preview_valid), .pieces_dealt(pieces_dealt)
    );

    tetris_piece_queue #(.PREVIEW_DEPTH(PD), .BAG_MODE(1'b0)) dut_rand (
        .clk(clk), .reset(r_reset), .seed_load(r_seed_load), .seed_in(r_seed_in), .take(r_take),
        .piece_valid(r_piece_valid), .piece(r_piece), .preview_types(r_preview_types),
        .preview_valid(r_preview_valid), .pieces_dealt(r_pieces_dealt)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        valid;
        bit [13:0] pc;
        bit [8:0]  pt;
        bit [2:0]  pv;
        bit [15:0] dealt;
    } exp_t;

    exp_t exp_q[$];
    int   deal_q[$];

    // Reference model: plain queue of types, 7-slot bag bitmap, integer LFSR.
    int       m_lfsr;
    int       mq[$];
    bit [6:0] m_bag;
    int       m_dealt;

    function automatic void model_step(bit r, bit sl, int si, bit tk);
        int c, n, s, pick;
        if (r) begin
            m_lfsr = 'hACE1; mq.delete(); m_bag = 7'h00; m_dealt = 0;
        end else if (sl) begin
            m_lfsr = (si == 0) ? 'hACE1 : si; mq.delete(); m_bag = 7'h00;
        end else begin
            c = m_lfsr % 8;
            n = mq.size();
            if (tk && n > 0) begin
                deal_q.push_back(mq.pop_front());
                m_dealt = (m_dealt + 1) % 65536;
            end
            if (n < PD + 1) begin
                s = (c == 7) ? 0 : c;
                pick = s;
                for (int k = 0; k < 7; k++) begin
                    pick = (s + k) % 7;
                    if (!m_bag[pick]) break;
                end
                mq.push_back(pick);
                m_bag[pick] = 1'b1;
                if (m_bag == 7'h7F) m_bag = 7'h00;
            end
            m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit [2:0] t0;
        e.valid = (mq.size() > 0);
        t0 = (mq.size() > 0) ? 3'(mq[0]) : 3'd0;
        e.pc = {t0, 2'd0, 4'd3, 5'd0};
        e.pt = 9'd0;
        e.pv = 3'd0;
        for (int i = 0; i < PD; i++) begin
            if (mq.size() > i + 1) begin
                e.pt[3*i +: 3] = 3'(mq[i+1]);
                e.pv[i] = 1'b1;
            end
        end
        e.dealt = 16'(m_dealt);
        return e;
    endfunction

    task automatic cycle(input bit r, input bit sl, input int si, input bit tk);
        reset = r; seed_load = sl; seed_in = 16'(si); take = tk;
        model_step(r, sl, si, tk);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    // Monitor: compares each cycle's outputs and every accepted deal, plus bag groups.
    logic     prev_valid = 1'b0;
    logic [2:0] prev_type = 3'd0;
    int       grp_n = 0;
    bit [6:0] grp_mask = 7'h00;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (take && !reset && !seed_load && prev_valid) begin
                if (deal_q.size() == 0) begin
                    check("deal_unexpected", 1, 0);
                end else begin
                    check("dealt_type", int'(prev_type), deal_q.pop_front());
                end
                grp_mask[prev_type] = 1'b1;
                grp_n++;
                if (grp_n == 7) begin
                    check("bag_permutation", int'(grp_mask), 'h7F);
                    grp_n = 0;
                    grp_mask = 7'h00;
                end
            end
            if (reset || seed_load) begin
                grp_n = 0;
                grp_mask = 7'h00;
            end
            if (exp_q.size() == 0) begin
                check("exp_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("piece_valid", int'(piece_valid), int'(e.valid));
                check("piece", int'(piece), int'(e.pc));
                check("preview_types", int'(preview_types), int'(e.pt));
                check("preview_valid", int'(preview_valid), int'(e.pv));
                check("pieces_dealt", int'(pieces_dealt), int'(e.dealt));
            end
            prev_valid = piece_valid;
            prev_type  = piece[13:11];
        end
    end

    initial begin
        int bad;
        int guard;
        r_reset = 1'b1; r_seed_load = 1'b0; r_seed_in = 16'h0000; r_take = 1'b0;

        // Fill after reset, with a take on the release cycle.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        repeat (4) cycle(0, 0, 0, 0);
        // Continuous takes across ten bags.
        repeat (72) cycle(0, 0, 0, 1);
        repeat (4) cycle(0, 0, 0, 0);
        // Take while full, then refill.
        cycle(0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0);
        // Seeded runs, seed 0 and a fresh reset.
        repeat (2) begin
            cycle(0, 1, 'h1234, 0);
            repeat (22) cycle(0, 0, 0, 1);
        end
        cycle(0, 1, 0, 0);
        repeat (22) cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        // Flush mid-operation with a coincident take.
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 'h4321, 1);
        repeat (3) cycle(0, 0, 0, 0);
        repeat (14) cycle(0, 0, 0, 1);
        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom % 400) == 0, ($urandom % 60) == 0,
                  (($urandom % 4) == 0) ? 0 : int'($urandom % 65536),
                  ($urandom % 3) != 0);
        end

        // Random mode: a seed of 7 rejects the first candidate.
        r_reset = 1'b1;
        cycle(0, 0, 0, 0);
        r_reset = 1'b0; r_seed_load = 1'b1; r_seed_in = 16'h0007;
        cycle(0, 0, 0, 0);
        check("rand_flush_empty", int'(r_piece_valid), 0);
        r_seed_load = 1'b0;
        cycle(0, 0, 0, 0);
        check("rand_reject_valid", int'(r_piece_valid), 0);
        check("rand_reject_preview", int'(r_preview_valid), 0);
        cycle(0, 0, 0, 0);
        check("rand_first_valid", int'(r_piece_valid), 1);
        check("rand_first_type", int'(r_piece[13:11]), 3);
        check("rand_spawn_fields", int'(r_piece[10:0]), 'h060);
        r_take = 1'b1;
        bad = 0;
        guard = 0;
        while (r_pieces_dealt < 16'd1000 && guard < 4000) begin
            cycle(0, 0, 0, 0);
            guard++;
            if (r_piece_valid && r_piece[13:11] == 3'd7) bad++;
            for (int i = 0; i < PD; i++) begin
                if (r_preview_valid[i] && r_preview_types[3*i +: 3] == 3'd7) bad++;
            end
        end
        check("rand_no_type7", bad, 0);
        check("rand_dealt_1000", int'(r_pieces_dealt), 1000);
        r_take = 1'b0;

        check("deal_queue_drained", deal_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
